seven_seg_scan: RTL and testbench

Parametrised, time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with full hex decode (0-F) per digit.
- Adds tear-free value loading, per-digit blanking, decimal points, leading-zero suppression and an anti-ghosting blank gap between digits.
- Sits between datapath result registers and board display pins; replaces the single-digit combinational decoder on multi-digit boards.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/hex_to_seg.sv | 32 +++
 rtl/seven_seg_scan.sv | 137 +++++++++++++
 tb/tb_seven_seg_scan.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns (bit 6 = a .. bit 0 = g) and a width helper for index counters.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// New values are staged in a pending register and only copied to the
// displayed register when the scan wraps, so a frame never mixes old and
// new data. A short all-dark gap after each digit switch avoids ghosting.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 2,
  localparam int IDX_W        = idx_w(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int PRE_W = idx_w(REFRESH_DIV);
  localparam int BLK_W = idx_w(BLANK_CYCLES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYCLES);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lz_en;
  } frame_t;

  logic [PRE_W-1:0]      prescaler;
  logic [BLK_W-1:0]      blank_cnt;
  frame_t                pending;
  frame_t                display;
  logic                  pend_valid;
  logic                  tick;
  logic                  wrap;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            cur_nib;
  logic [6:0]            hex_seg;
  logic                  suppressed;
  logic                  blanked;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (digit_idx == IDX_LAST);

  // Prescaler, digit pointer and post-switch blank gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      digit_idx <= '0;
      blank_cnt <= '0;
    end else if (tick) begin
      prescaler <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      blank_cnt <= BLK_LOAD;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
    end
  end

  // Pending/display shadow pair; a load on the wrap edge stays pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      display    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (wrap && pend_valid) display <= pending;
      if (load) begin
        pending    <= '{value: value, dp_mask: dp_in, blank_mask: blank_in, lz_en: lz_en};
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Split the displayed value into nibbles and flag digits with only zeros at or above them.
  always_comb begin
    zero_from = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i]       = display.value[4*i +: 4];
      zero_from[i] = ~|(display.value >> (4*i));
    end
  end

  assign cur_nib    = nib[digit_idx];
  assign suppressed = display.lz_en && (digit_idx != '0) && zero_from[digit_idx];
  assign blanked    = display.blank_mask[digit_idx];

  hex_to_seg u_hex (
    .nibble (cur_nib),
    .seg    (hex_seg)
  );

  // Next output values for the addressed digit, with blanking taking priority.
  always_comb begin
    seg_next = hex_seg;
    dp_next  = ~display.dp_mask[digit_idx];
    an_next  = ~(NUM_DIGITS'(1) << digit_idx);
    if (suppressed || blanked) seg_next = SEG_OFF;
    if (blanked) dp_next = 1'b1;
    if (tick || (blank_cnt != '0)) an_next = '1;
  end

  // Registered pin outputs and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dp         <= dp_next;
      an         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 4 clocks per digit, 1 blank cycle).
// Expected lit windows of each frame are queued from the data the bench loaded
// and popped as the DUT lights each digit.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  seven_seg_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] hex_pat(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv,
                         input logic [3:0] blk, input logic lz);
    value    = v;
    dp_in    = dpv;
    blank_in = blk;
    lz_en    = lz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic sync_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_sync"}, {31'd0, found}, 32'd1);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv,
                            input logic [3:0] blk, input logic lz);
    for (int d = 0; d < 4; d++) begin
      exp_t       e;
      logic [3:0] nb;
      logic       sup;
      nb    = v[4*d +: 4];
      sup   = lz && (d > 0) && ((v >> (4*d)) == 16'h0000);
      e.an  = ~(4'b0001 << d);
      e.seg = (blk[d] || sup) ? 7'b1111111 : hex_pat(nb);
      e.dp  = blk[d] ? 1'b1 : ~dpv[d];
      exp_q.push_back(e);
    end
  endtask

  // Called at the negedge where frame_done is high; ends at the next such negedge.
  task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                             input logic [3:0] blk, input logic lz);
    int   lit;
    int   fd;
    logic was_lit;
    lit     = 0;
    fd      = 0;
    was_lit = 1'b0;
    push_frame(v, dpv, blk, lz);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd++;
      if (an !== 4'hF) begin
        lit++;
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_window"}, {28'd0, an}, 32'hF);
        end else begin
          chk({tag, "_an"},  {28'd0, an},  {28'd0, exp_q[0].an});
          chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_q[0].seg});
          chk({tag, "_dp"},  {31'd0, dp},  {31'd0, exp_q[0].dp});
        end
        was_lit = 1'b1;
      end else if (was_lit) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        was_lit = 1'b0;
      end
    end
    chk({tag, "_lit_cycles"}, lit, 32'd8);
    chk({tag, "_windows_left"}, exp_q.size(), 32'd0);
    chk({tag, "_frame_pulses"}, fd, 32'd1);
    chk({tag, "_frame_end"}, {31'd0, frame_done}, 32'd1);
    exp_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    value    = '0;
    dp_in    = '0;
    blank_in = '0;
    lz_en    = 1'b0;
    load     = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_digit_idx", {30'd0, digit_idx}, 32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("first_an", {28'd0, an}, 32'hE);
    chk("first_seg", {25'd0, seg}, 32'h01);
    chk("first_idx", {30'd0, digit_idx}, 32'd0);

    // Basic scan order
    do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    sync_frame("scan");
    check_frame("scan", 16'h12AF, 4'b0000, 4'b0000, 1'b0);

    // Tear-free update: two loads mid-frame, only the last one appears next frame
    fork
      check_frame("tear_cur", 16'h12AF, 4'b0000, 4'b0000, 1'b0);
      begin
        repeat (4) @(negedge clk);
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
      end
    join
    check_frame("tear_next", 16'h1111, 4'b0000, 4'b0000, 1'b0);

    // Leading-zero suppression
    do_load(16'h0070, 4'b0000, 4'b0000, 1'b1);
    sync_frame("lz_0070");
    check_frame("lz_0070", 16'h0070, 4'b0000, 4'b0000, 1'b1);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    sync_frame("lz_zero");
    check_frame("lz_zero", 16'h0000, 4'b0000, 4'b0000, 1'b1);

    // Blanking beats dp; dp still shown on a suppressed digit
    do_load(16'h12AF, 4'b0101, 4'b0100, 1'b0);
    sync_frame("blank_dp");
    check_frame("blank_dp", 16'h12AF, 4'b0101, 4'b0100, 1'b0);
    do_load(16'h0005, 4'b0010, 4'b0000, 1'b1);
    sync_frame("lz_dp");
    check_frame("lz_dp", 16'h0005, 4'b0010, 4'b0000, 1'b1);

    // Load landing on the wrap edge: older pending shows first
    fork
      check_frame("coin_cur", 16'h0005, 4'b0010, 4'b0000, 1'b1);
      begin
        repeat (4) @(negedge clk);
        do_load(16'h9876, 4'b0000, 4'b0000, 1'b0);
        repeat (10) @(negedge clk);
        do_load(16'h3C4E, 4'b1000, 4'b0000, 1'b0);
      end
    join
    check_frame("coin_prev", 16'h9876, 4'b0000, 4'b0000, 1'b0);
    check_frame("coin_new", 16'h3C4E, 4'b1000, 4'b0000, 1'b0);

    // Asynchronous reset while digit 2 is lit
    repeat (10) @(negedge clk);
    chk("mid_idx", {30'd0, digit_idx}, 32'd2);
    chk("mid_an", {28'd0, an}, 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    chk("async_rst_idx", {30'd0, digit_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", {28'd0, an}, 32'hE);
    chk("post_rst_idx", {30'd0, digit_idx}, 32'd0);
    chk("post_rst_seg", {25'd0, seg}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
